// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time ROM loader.
// Optional checksum stage is enabled with the ROM_LOADER_CHECKSUM_EN macro.
package rom_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_DATA   = 3'd1,
        S_CHECK  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/rom_loader_assembler.sv
// Big-endian byte-to-word assembler: the first accepted byte of a word ends
// up in bits [31:24]. o_word_valid pulses combinationally during the cycle in
// which the fourth byte is being accepted, with o_word holding the full word.
module rom_loader_assembler
    import rom_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_accept,
    input  logic                  i_clear,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic                  o_word_valid,
    output logic [WORD_WIDTH-1:0] o_word
);

    logic [1:0]            r_byte_cnt;
    logic [WORD_WIDTH-1:0] r_shift;

    // Byte counter and shift register; a clear drops any partial word
    // together with a byte accepted in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else if (i_clear) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else if (i_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[WORD_WIDTH-BYTE_WIDTH-1:0], i_byte};
        end
    end

    assign o_word_valid = i_accept && !i_clear && (r_byte_cnt == 2'(WORD_BYTES - 1));
    assign o_word       = {r_shift[WORD_WIDTH-BYTE_WIDTH-1:0], i_byte};

endmodule

// File: rtl/rom_loader.sv
// Boot-time program loader: takes a byte stream (header word = word count,
// then data words, big-endian), writes the words into instruction memory and
// holds the CPU in reset until the image is complete.
// Defining ROM_LOADER_CHECKSUM_EN adds a trailing checksum word that must
// equal the mod-2^32 sum of the data words before the CPU is released.
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
// byte_ready depends only on state (and reset), never on byte_valid.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int BASE_ADDRESS  = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [BYTE_WIDTH-1:0]    byte_data,
    output logic                     byte_ready,
    input  logic                     restart,
    output logic                     rom_write_enable,
    output logic [ADDRESS_WIDTH-1:0] rom_write_address,
    output logic [WORD_WIDTH-1:0]    rom_write_data,
    output logic                     cpu_reset,
    output logic                     load_done,
    output logic                     load_error,
    output logic [2:0]               o_dbg_state
);

    // Largest legal word count is the full memory depth.
    localparam logic [WORD_WIDTH:0]    MAX_WORDS = 33'd1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] ONE_IDX   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] BASE_W  = ADDRESS_WIDTH'(BASE_ADDRESS);
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHECK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t                   r_state;
    logic [ADDRESS_WIDTH:0]   r_word_count;
    logic [ADDRESS_WIDTH:0]   r_index;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0]    r_data;
    logic                     r_cpu_reset;
    logic                     r_load_done;
    logic                     r_load_error;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]    r_sum;
`endif

    logic                  w_accept;
    logic                  w_word_valid;
    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_too_big;
    logic                  w_last_word;

    assign byte_ready  = reset && ((r_state == S_HEADER) || (r_state == S_DATA) ||
                                   (r_state == S_CHECK));
    assign w_accept    = byte_valid && byte_ready;
    assign w_too_big   = {1'b0, w_word} > MAX_WORDS;
    assign w_last_word = (r_index == (r_word_count - ONE_IDX));

    rom_loader_assembler u_assembler (
        .clock        (clock),
        .reset        (reset),
        .i_accept     (w_accept),
        .i_clear      (restart),
        .i_byte       (byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Load FSM with registered write port and status outputs. Status flags
    // follow the state one cycle later, so the CPU is released the cycle
    // after the final write strobe (or after the checksum is accepted).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HEADER;
            r_word_count <= '0;
            r_index      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (restart) begin
                r_state      <= S_HEADER;
                r_word_count <= '0;
                r_index      <= '0;
                r_cpu_reset  <= 1'b1;
                r_load_done  <= 1'b0;
                r_load_error <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                r_sum        <= '0;
`endif
            end else begin
                r_cpu_reset  <= (r_state != S_DONE);
                r_load_done  <= (r_state == S_DONE);
                r_load_error <= (r_state == S_ERROR);
                case (r_state)
                    S_HEADER: begin
                        if (w_word_valid) begin
                            r_index <= '0;
                            if (w_too_big) begin
                                r_state <= S_ERROR;
                            end else if (w_word == '0) begin
                                r_state <= S_AFTER_DATA;
                            end else begin
                                r_word_count <= w_word[ADDRESS_WIDTH:0];
                                r_state      <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_word_valid) begin
                            r_we    <= 1'b1;
                            r_addr  <= BASE_W + r_index[ADDRESS_WIDTH-1:0];
                            r_data  <= w_word;
                            r_index <= r_index + ONE_IDX;
`ifdef ROM_LOADER_CHECKSUM_EN
                            r_sum   <= r_sum + w_word;
`endif
                            if (w_last_word) begin
                                r_state <= S_AFTER_DATA;
                            end
                        end
                    end
`ifdef ROM_LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (w_word_valid) begin
                            r_state <= (w_word == r_sum) ? S_DONE : S_ERROR;
                        end
                    end
`endif
                    S_DONE:  r_state <= S_DONE;
                    S_ERROR: r_state <= S_ERROR;
                    default: r_state <= S_HEADER;
                endcase
            end
        end
    end

    assign rom_write_enable  = r_we;
    assign rom_write_address = r_addr;
    assign rom_write_data    = r_data;
    assign cpu_reset         = r_cpu_reset;
    assign load_done         = r_load_done;
    assign load_error        = r_load_error;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader. Two instances: u_dut0 with BASE_ADDRESS=0
// and u_dut1 with BASE_ADDRESS=1020 for the address wrap case.
// Build with ROM_LOADER_CHECKSUM_EN defined to exercise the checksum stage.
module tb_rom_loader;
    import rom_loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- DUT signals ----------------
    logic        byte_valid [2];
    logic [7:0]  byte_data  [2];
    logic        restart    [2];
    logic        byte_ready [2];
    logic        rom_we     [2];
    logic [9:0]  rom_addr   [2];
    logic [31:0] rom_data   [2];
    logic        cpu_rst    [2];
    logic        load_done  [2];
    logic        load_error [2];
    logic [2:0]  dbg_state  [2];

    rom_loader #(.ADDRESS_WIDTH(10), .BASE_ADDRESS(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .byte_valid(byte_valid[0]), .byte_data(byte_data[0]), .byte_ready(byte_ready[0]),
        .restart(restart[0]),
        .rom_write_enable(rom_we[0]), .rom_write_address(rom_addr[0]),
        .rom_write_data(rom_data[0]),
        .cpu_reset(cpu_rst[0]), .load_done(load_done[0]), .load_error(load_error[0]),
        .o_dbg_state(dbg_state[0])
    );

    rom_loader #(.ADDRESS_WIDTH(10), .BASE_ADDRESS(1020)) u_dut1 (
        .clock(clock), .reset(reset),
        .byte_valid(byte_valid[1]), .byte_data(byte_data[1]), .byte_ready(byte_ready[1]),
        .restart(restart[1]),
        .rom_write_enable(rom_we[1]), .rom_write_address(rom_addr[1]),
        .rom_write_data(rom_data[1]),
        .cpu_reset(cpu_rst[1]), .load_done(load_done[1]), .load_error(load_error[1]),
        .o_dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [41:0] exp_q0[$];
    logic [41:0] exp_q1[$];
    int strobe_cnt [2] = '{0, 0};
    int last_strobe[2] = '{0, 0};
    int fall_cyc   [2] = '{0, 0};
    logic prev_cpu [2] = '{1'b1, 1'b1};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Write-port monitor: every strobe must match the next expected (addr,data).
    always @(negedge clock) begin
        logic [41:0] e;
        bit          have;
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                if (rom_we[s]) begin
                    strobe_cnt[s]++;
                    last_strobe[s] = cyc;
                    have = 1'b0;
                    e    = '0;
                    if (s == 0 && exp_q0.size() > 0) begin
                        e = exp_q0.pop_front(); have = 1'b1;
                    end else if (s == 1 && exp_q1.size() > 0) begin
                        e = exp_q1.pop_front(); have = 1'b1;
                    end
                    if (!have) begin
                        check("unexpected_strobe", 64'(rom_we[s]), 64'd0);
                    end else begin
                        check("wr_addr", 64'(rom_addr[s]), 64'(e[41:32]));
                        check("wr_data", 64'(rom_data[s]), 64'(e[31:0]));
                    end
                end
                if (prev_cpu[s] && !cpu_rst[s]) fall_cyc[s] = cyc;
                prev_cpu[s] = cpu_rst[s];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input int s, input logic [7:0] b);
        int n;
        n = 0;
        byte_valid[s] = 1'b1;
        byte_data[s]  = b;
        while (n < 40) begin
            @(negedge clock);
            if (byte_ready[s]) break;
            n++;
        end
        if (n >= 40) check("ready_timeout", 64'(byte_ready[s]), 64'd1);
        @(posedge clock);
        #1;
        byte_valid[s] = 1'b0;
    endtask

    task automatic send_word(input int s, input logic [31:0] w, input int max_gap);
        int gap;
        for (int i = 0; i < 4; i++) begin
            send_byte(s, w[31-8*i -: 8]);
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
                repeat (gap) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic send_checksum(input int s, input logic [31:0] sum);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_word(s, sum, 0);
`else
        if (sum === 32'hx) $display("checksum stage not built");
`endif
    endtask

    task automatic do_restart(input int s, input logic with_byte);
        restart[s]    = 1'b1;
        byte_valid[s] = with_byte;
        byte_data[s]  = 8'hEE;
        @(posedge clock);
        #1;
        restart[s]    = 1'b0;
        byte_valid[s] = 1'b0;
    endtask

    task automatic push_exp(input int s, input logic [9:0] a, input logic [31:0] d);
        if (s == 0) exp_q0.push_back({a, d});
        else        exp_q1.push_back({a, d});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base_cnt;
        logic [31:0] words [6];
        words = '{32'hA0000001, 32'hA0000002, 32'hA0000003,
                  32'hA0000004, 32'hA0000005, 32'hA0000006};

        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            byte_valid[s] = 1'b0; byte_data[s] = 8'h00; restart[s] = 1'b0;
        end

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_we",    64'(rom_we[0]),     64'd0);
        check("rst_addr",  64'(rom_addr[0]),   64'd0);
        check("rst_data",  64'(rom_data[0]),   64'd0);
        check("rst_cpu",   64'(cpu_rst[0]),    64'd1);
        check("rst_done",  64'(load_done[0]),  64'd0);
        check("rst_err",   64'(load_error[0]), 64'd0);
        check("rst_ready", 64'(byte_ready[0]), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_cycles(2);
        check("idle_ready", 64'(byte_ready[0]), 64'd1);
        check("idle_state", 64'(dbg_state[0]),  64'(S_HEADER));

        // Two words back-to-back
        push_exp(0, 10'd0, 32'h3C010001);
        push_exp(0, 10'd1, 32'h34210002);
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h3C010001, 0);
        send_word(0, 32'h34210002, 0);
        send_checksum(0, 32'h70220003);
        wait_cycles(4);
        check("t1_drain",   64'(exp_q0.size()), 64'd0);
        check("t1_strobes", 64'(strobe_cnt[0]), 64'd2);
        check("t1_cpu",     64'(cpu_rst[0]),    64'd0);
        check("t1_done",    64'(load_done[0]),  64'd1);
        check("t1_ready",   64'(byte_ready[0]), 64'd0);
`ifndef ROM_LOADER_CHECKSUM_EN
        check("t1_release_lag", 64'(fall_cyc[0] - last_strobe[0]), 64'd1);
`endif
        do_restart(0, 1'b0);
        wait_cycles(1);
        check("rs_cpu",   64'(cpu_rst[0]),    64'd1);
        check("rs_done",  64'(load_done[0]),  64'd0);
        check("rs_ready", 64'(byte_ready[0]), 64'd1);

        // Empty image
        base_cnt = strobe_cnt[0];
        send_word(0, 32'h00000000, 0);
        send_checksum(0, 32'h00000000);
        wait_cycles(3);
        check("t2_done",    64'(load_done[0]),  64'd1);
        check("t2_cpu",     64'(cpu_rst[0]),    64'd0);
        check("t2_strobes", 64'(strobe_cnt[0]), 64'(base_cnt));
        do_restart(0, 1'b0);

        // Oversize header
        send_word(0, 32'h00000401, 0);
        wait_cycles(3);
        check("t3_err",     64'(load_error[0]), 64'd1);
        check("t3_ready",   64'(byte_ready[0]), 64'd0);
        check("t3_cpu",     64'(cpu_rst[0]),    64'd1);
        check("t3_done",    64'(load_done[0]),  64'd0);
        check("t3_strobes", 64'(strobe_cnt[0]), 64'(base_cnt));
        do_restart(0, 1'b0);
        wait_cycles(1);
        check("t3_err_clr", 64'(load_error[0]), 64'd0);

        // Upper header bits must not be ignored
        send_word(0, 32'h80000001, 0);
        wait_cycles(3);
        check("t3b_err", 64'(load_error[0]), 64'd1);
        do_restart(0, 1'b0);

        // Exactly full memory depth is legal
        send_word(0, 32'h00000400, 0);
        wait_cycles(3);
        check("t3c_err",   64'(load_error[0]), 64'd0);
        check("t3c_state", 64'(dbg_state[0]),  64'(S_DATA));
        check("t3c_ready", 64'(byte_ready[0]), 64'd1);
        do_restart(0, 1'b0);

        // Restart in the middle of a word, colliding with a byte
        base_cnt = strobe_cnt[0];
        push_exp(0, 10'd0, 32'h11223344);
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h11223344, 0);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        do_restart(0, 1'b1);
        wait_cycles(2);
        check("t4_state",   64'(dbg_state[0]),  64'(S_HEADER));
        check("t4_strobes", 64'(strobe_cnt[0]), 64'(base_cnt + 1));
        check("t4_cpu",     64'(cpu_rst[0]),    64'd1);
        push_exp(0, 10'd0, 32'h55667788);
        send_word(0, 32'h00000001, 0);
        send_word(0, 32'h55667788, 1);
        send_checksum(0, 32'h55667788);
        wait_cycles(4);
        check("t4_done",    64'(load_done[0]),  64'd1);
        check("t4_drain",   64'(exp_q0.size()), 64'd0);
        check("t4_strobes2",64'(strobe_cnt[0]), 64'(base_cnt + 2));

        // Address wrap with random byte gaps on the BASE_ADDRESS=1020 instance
        push_exp(1, 10'd1020, words[0]);
        push_exp(1, 10'd1021, words[1]);
        push_exp(1, 10'd1022, words[2]);
        push_exp(1, 10'd1023, words[3]);
        push_exp(1, 10'd0,    words[4]);
        push_exp(1, 10'd1,    words[5]);
        send_word(1, 32'h00000006, 3);
        for (int i = 0; i < 6; i++) send_word(1, words[i], 3);
        send_checksum(1, 32'hC0000015);
        wait_cycles(4);
        check("t5_drain",   64'(exp_q1.size()),  64'd0);
        check("t5_strobes", 64'(strobe_cnt[1]),  64'd6);
        check("t5_done",    64'(load_done[1]),   64'd1);
        check("t5_state",   64'(dbg_state[1]),   64'(S_DONE));
        check("t5_cpu",     64'(cpu_rst[1]),     64'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_restart(0, 1'b0);
        push_exp(0, 10'd0, 32'h00000001);
        push_exp(0, 10'd1, 32'h00000002);
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h00000001, 0);
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h00000003, 0);
        wait_cycles(3);
        check("t6_done", 64'(load_done[0]),  64'd1);
        check("t6_cpu",  64'(cpu_rst[0]),    64'd0);
        do_restart(0, 1'b0);
        push_exp(0, 10'd0, 32'h00000001);
        push_exp(0, 10'd1, 32'h00000002);
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h00000001, 0);
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h00000004, 0);
        wait_cycles(3);
        check("t6_err",   64'(load_error[0]), 64'd1);
        check("t6_cpu2",  64'(cpu_rst[0]),    64'd1);
        check("t6_drain", 64'(exp_q0.size()), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time program loader for the SOPC.
- Receives a byte stream (e.g. from a UART receiver) and writes 32-bit instruction words into the instruction ROM storage through a write port.
- Holds the CPU in reset until the image is written, then releases it.
- Hardware counterpart of the bench-side ROM image load.

Parameters:
ADDRESS_WIDTH, 10, word-address width of the instruction memory write port
BASE_ADDRESS, 0, word address of the first loaded word

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
byte_valid  input  1  source has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
restart  input  1  synchronous request to abort/rerun the load
rom_write_enable  output  1  one-cycle write strobe to instruction memory
rom_write_address  output  ADDRESS_WIDTH  word address of the write
rom_write_data  output  32  instruction word
cpu_reset  output  1  active-high hold of the CPU core
load_done  output  1  image loaded and CPU released
load_error  output  1  load rejected; CPU stays held

Behaviour:
- Reset (reset low, asynchronous): state HEADER, byte/word counters 0, assembly register 0.
  - Outputs while reset is low: rom_write_enable=0, rom_write_address=0, rom_write_data=0, cpu_reset=1, load_done=0, load_error=0, byte_ready=0.
- Handshake: a byte is accepted on a rising edge with byte_valid && byte_ready.
  - byte_ready is combinational from state: 1 in HEADER/DATA/CHECK, 0 in DONE/ERROR.
  - byte_ready does not depend on byte_valid.
- Word assembly: big-endian, first byte to bits [31:24]; byte counter 0..3, wraps to 0 after the 4th byte.
- HEADER: the 4 bytes form word_count (32-bit).
  - word_count > 2^ADDRESS_WIDTH (33-bit compare): go to ERROR.
  - word_count == 0: go to DONE (CHECK if the macro is defined).
  - Otherwise go to DATA, word index = 0.
- DATA: on acceptance of the 4th byte of each word, the next cycle has:
  - rom_write_enable=1;
  - rom_write_address = (BASE_ADDRESS + index) mod 2^ADDRESS_WIDTH;
  - rom_write_data = the assembled word.
  - The strobe lasts exactly one cycle; address/data hold their last values afterwards.
  - After the word with index word_count-1, go to DONE (or CHECK).
- DONE: cpu_reset falls in the cycle after the final write strobe; load_done=1. The loader stays in DONE until restart or reset.
- ERROR: load_error=1; cpu_reset stays 1; no writes.
- restart in any state: next state HEADER, counters and partial word cleared, cpu_reset=1, load_done=0, load_error=0, no pending strobe issued.
  - restart has priority over a simultaneous byte acceptance; that byte is consumed and discarded.
- Back-to-back bytes every cycle are supported with no stalls; byte gaps of any length are tolerated.
- Memory contents written before an abort remain; a rerun overwrites them.

Optional Feature:
ROM_LOADER_CHECKSUM_EN
- Defined:
  - After the last data word (or after the header if word_count=0), state CHECK receives one more big-endian 32-bit word.
  - That word must equal the sum mod 2^32 of all data words.
  - Match: go to DONE, release the CPU in the next cycle.
  - Mismatch: go to ERROR.
  - The checksum word is never written to memory.
- Not defined: the CHECK state and the sum accumulator are absent; DATA goes directly to DONE.

Decomposition:
- Package rom_loader_pkg:
  - state enumeration (HEADER, DATA, CHECK, DONE, ERROR);
  - WORD_BYTES=4, BYTE_WIDTH=8, WORD_WIDTH=32.
- Sub-module rom_loader_assembler: byte counter plus shift register.
  - Outputs word_valid (single-cycle pulse on the 4th byte) and word.
  - Clearable by restart.
- The top level holds the FSM, word index, address, strobe and checksum.

Test Plan:
- Header 00000002, words 3C010001, 34210002 streamed back-to-back -> strobes at addresses 0 and 1 with those data; cpu_reset falls 1 cycle after the second strobe; load_done=1.
- Header 00000000 -> no strobes, load_done=1, cpu_reset=0 (with macro: also send 00000000 as the checksum first).
- Header 00000401 with ADDRESS_WIDTH=10 -> load_error=1, byte_ready=0, cpu_reset stays 1, no strobes.
- restart asserted after 2 bytes of the second data word -> no strobe for that word; a fresh header is then accepted; full reload writes address 0 again.
- Random byte_valid gaps, BASE_ADDRESS=1020, 6 words -> addresses 1020..1023, 0, 1 (wrap); data matches the stream.
- Macro defined: words 00000001, 00000002 with checksum 00000003 -> DONE; checksum 00000004 -> ERROR, cpu_reset stays 1.
